// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, prescale floor,
// legal data-width range and the 2-of-3 vote used by the bit sampler.
package uart_pkg;

  localparam int PRESCALE_MIN = 4;
  localparam int DATA_W_MIN   = 5;
  localparam int DATA_W_MAX   = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop line synchroniser, falling-edge detector and 3-sample majority voter.
// The vote combines two stored samples with the live synchronised line value.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  input  logic sample_i,
  output logic fall_o,
  output logic maj_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic [1:0] samp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      samp_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      prev_q <= sync_q[1];
      if (sample_i) begin
        samp_q <= {samp_q[0], sync_q[1]};
      end
    end
  end

  // A held-low line never produces a new edge, which gives break lockout for free.
  assign fall_o = prev_q & ~sync_q[1];
  assign maj_o  = maj3(samp_q[1], samp_q[0], sync_q[1]);

endmodule

// File: rtl/uart_rx_gen.sv
// Configurable UART receiver: start/data/parity/stop FSM with per-frame latched
// configuration and a one-deep output holding register with overrun signalling.
module uart_rx_gen
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic                  data_ready,
  output logic [DATA_W-1:0]     P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error,
  output logic                  overrun
);

  localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] P_MIN    = PRESCALE_W'(PRESCALE_MIN);
  localparam logic [3:0]            BIT_LAST = 4'(DATA_W - 1);

  rx_state_e             state_q, state_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d, presc_q, presc_d;
  logic [3:0]            bit_q, bit_d;
  logic                  stop_q, stop_d;
  logic                  par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
  logic [DATA_W-1:0]     data_q, data_d, p_data_q, p_data_d;
  logic                  par_err_q, par_err_d, stop_err_q, stop_err_d, commit_q, commit_d;
  logic                  valid_q, valid_d, perr_out_q, perr_out_d;
  logic                  serr_out_q, serr_out_d, ovr_q, ovr_d;
  logic                  fall, maj, busy, sample_en, decide, last_cnt;
  logic [PRESCALE_W-1:0] half;

  assign busy      = (state_q != ST_IDLE);
  assign half      = presc_q >> 1;
  assign last_cnt  = (cnt_q == presc_q - ONE);
  assign sample_en = busy && ((cnt_q == half - ONE) || (cnt_q == half));
  assign decide    = busy && (cnt_q == half + ONE);

  uart_rx_sampler u_sampler (
    .clk      (clk),
    .rst      (rst),
    .rx_i     (RX_IN),
    .sample_i (sample_en),
    .fall_o   (fall),
    .maj_o    (maj)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = (busy && !last_cnt) ? cnt_q + ONE : '0;
    presc_d    = presc_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    stop2_d    = stop2_q;
    data_d     = data_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    commit_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d    = ST_START;
          cnt_d      = '0;
          presc_d    = (prescale < P_MIN) ? P_MIN : prescale;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          stop2_d    = STOP2;
          bit_d      = '0;
          stop_d     = 1'b0;
          par_err_d  = 1'b0;
          stop_err_d = 1'b0;
        end
      end
      ST_START: begin
        if (decide && maj) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (last_cnt) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (decide) begin
          data_d = {maj, data_q[DATA_W-1:1]};
        end
        if (last_cnt) begin
          if (bit_q == BIT_LAST) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (decide) begin
          par_err_d = ((^data_q) ^ maj) != par_typ_q;
        end
        if (last_cnt) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // The last stop bit ends the frame at its vote; its tail is not waited out.
        if (decide) begin
          if (!maj) begin
            stop_err_d = 1'b1;
          end
          if (stop_q == stop2_q) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            commit_d = 1'b1;
          end
        end
        if (last_cnt) begin
          stop_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    p_data_d   = p_data_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    serr_out_d = serr_out_q;
    ovr_d      = 1'b0;
    if (commit_q) begin
      if (!valid_q || data_ready) begin
        p_data_d   = data_q;
        perr_out_d = par_err_q;
        serr_out_d = stop_err_q;
        valid_d    = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      presc_q    <= P_MIN;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      data_q     <= '0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      commit_q   <= 1'b0;
      p_data_q   <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      serr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      presc_q    <= presc_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      stop2_q    <= stop2_d;
      data_q     <= data_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      commit_q   <= commit_d;
      p_data_q   <= p_data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      serr_out_q <= serr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign P_DATA       = p_data_q;
  assign data_valid   = valid_q;
  assign parity_error = perr_out_q;
  assign stop_error   = serr_out_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_uart_rx_gen.sv
// Directed bench for uart_rx_gen: an 8-bit instance for most frames and a
// 7-bit instance for the two-stop-bit odd-parity case.
module tb_uart_rx_gen;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx8 = 1'b1, rx7 = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0, par_typ = 1'b0, stop2 = 1'b0;
  logic       rdy8 = 1'b1, rdy7 = 1'b0;
  logic [7:0] pd8;
  logic [6:0] pd7;
  logic       dv8, pe8, se8, ov8, dv7, pe7, se7, ov7;

  int errors = 0;
  int checks = 0;
  logic [7:0] q_data[$];
  logic       q_pe[$];
  logic       q_se[$];
  int ovr_cycles = 0;
  int rd = 0;
  int ov_base;

  always #5 clk = ~clk;

  uart_rx_gen #(.DATA_W(8), .PRESCALE_W(6)) u8 (
    .clk(clk), .rst(rst), .RX_IN(rx8), .prescale(prescale), .PAR_EN(par_en),
    .PAR_TYP(par_typ), .STOP2(stop2), .data_ready(rdy8), .P_DATA(pd8),
    .data_valid(dv8), .parity_error(pe8), .stop_error(se8), .overrun(ov8)
  );

  uart_rx_gen #(.DATA_W(7), .PRESCALE_W(6)) u7 (
    .clk(clk), .rst(rst), .RX_IN(rx7), .prescale(prescale), .PAR_EN(par_en),
    .PAR_TYP(par_typ), .STOP2(stop2), .data_ready(rdy7), .P_DATA(pd7),
    .data_valid(dv7), .parity_error(pe7), .stop_error(se7), .overrun(ov7)
  );

  // Record every accepted frame of the 8-bit instance and its overrun cycles.
  always @(negedge clk) begin
    if (dv8 && rdy8) begin
      q_data.push_back(pd8);
      q_pe.push_back(pe8);
      q_se.push_back(se8);
      $display("accepted frame data=%02h parity_error=%0b stop_error=%0b", pd8, pe8, se8);
    end
    if (ov8) ovr_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit on7, input logic [8:0] data, input int nbits, input int p,
                      input logic has_par, input logic par_bit, input int nstop,
                      input logic [1:0] stops, input int rst_at);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
    if (has_par) bits.push_back(par_bit);
    for (int i = 0; i < nstop; i++) bits.push_back(stops[i]);
    for (int b = 0; b < bits.size(); b++) begin
      if (b == rst_at) rst = 1'b1;
      if (on7) rx7 = bits[b];
      else     rx8 = bits[b];
      idle(p);
    end
    rx7 = 1'b1;
    rx8 = 1'b1;
    $display("sent frame data=%03h bits=%0d", data, nbits);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe, input logic se);
    check({tag, "_present"}, 32'(q_data.size() > rd), 32'd1);
    if (q_data.size() > rd) begin
      check({tag, "_data"}, 32'(q_data[rd]), 32'(d));
      check({tag, "_perr"}, 32'(q_pe[rd]), 32'(pe));
      check({tag, "_serr"}, 32'(q_se[rd]), 32'(se));
      rd++;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(dv8), 32'd0);
    check("rst_pdata", 32'(pd8), 32'd0);
    check("rst_perr", 32'(pe8), 32'd0);
    check("rst_serr", 32'(se8), 32'd0);
    check("rst_ovr", 32'(ov8), 32'd0);
    check("rst_state", 32'(u8.state_q == ST_IDLE), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(4);

    // 8N1 back-to-back frames
    send(0, 9'h0A5, 8, 8, 1'b0, 1'b0, 1, 2'b11, -1);
    send(0, 9'h03C, 8, 8, 1'b0, 1'b0, 1, 2'b11, -1);
    idle(16);
    expect_frame("8n1_a5", 8'hA5, 1'b0, 1'b0);
    expect_frame("8n1_3c", 8'h3C, 1'b0, 1'b0);

    // even parity, wrong parity bit
    par_en = 1'b1;
    send(0, 9'h055, 8, 8, 1'b1, 1'b1, 1, 2'b11, -1);
    par_en = 1'b0;
    idle(16);
    expect_frame("par_55", 8'h55, 1'b1, 1'b0);

    // 2-cycle glitch rejected, then a normal frame
    rx8 = 1'b0;
    idle(2);
    rx8 = 1'b1;
    idle(24);
    @(negedge clk);
    check("glitch_state", 32'(u8.state_q == ST_IDLE), 32'd1);
    check("glitch_no_frame", 32'(q_data.size()), 32'(rd));
    check("glitch_valid", 32'(dv8), 32'd0);
    idle(1);
    send(0, 9'h05A, 8, 8, 1'b0, 1'b0, 1, 2'b11, -1);
    idle(16);
    expect_frame("glitch_5a", 8'h5A, 1'b0, 1'b0);

    // 7-bit, odd parity, two stop bits with the second one low
    prescale = 6'd16; par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b1;
    send(1, 9'h03F, 7, 16, 1'b1, 1'b1, 2, 2'b01, -1);
    prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    idle(40);
    @(negedge clk);
    check("d7_valid", 32'(dv7), 32'd1);
    check("d7_data", 32'(pd7), 32'h3F);
    check("d7_perr", 32'(pe7), 32'd0);
    check("d7_serr", 32'(se7), 32'd1);
    idle(1);

    // overrun: consumer stalled across two frames
    rdy8 = 1'b0;
    ov_base = ovr_cycles;
    send(0, 9'h011, 8, 8, 1'b0, 1'b0, 1, 2'b11, -1);
    send(0, 9'h022, 8, 8, 1'b0, 1'b0, 1, 2'b11, -1);
    idle(16);
    @(negedge clk);
    check("ovr_valid", 32'(dv8), 32'd1);
    check("ovr_pdata", 32'(pd8), 32'h11);
    check("ovr_pulse_cycles", 32'(ovr_cycles - ov_base), 32'd1);
    check("ovr_now_low", 32'(ov8), 32'd0);
    @(posedge clk);
    #1 rdy8 = 1'b1;
    idle(1);
    @(negedge clk);
    check("ovr_valid_cleared", 32'(dv8), 32'd0);
    expect_frame("ovr_held", 8'h11, 1'b0, 1'b0);
    check("ovr_dropped", 32'(q_data.size()), 32'(rd));
    idle(1);

    // break: 12 bit times low
    rx8 = 1'b0;
    idle(96);
    rx8 = 1'b1;
    idle(32);
    expect_frame("break", 8'h00, 1'b0, 1'b1);
    check("break_single", 32'(q_data.size()), 32'(rd));

    // reset asserted in the middle of a frame
    send(0, 9'h0C3, 8, 8, 1'b0, 1'b0, 1, 2'b11, 4);
    idle(3);
    rst = 1'b0;
    idle(32);
    @(negedge clk);
    check("rst_mid_no_frame", 32'(q_data.size()), 32'(rd));
    check("rst_mid_valid", 32'(dv8), 32'd0);
    check("rst_mid_state", 32'(u8.state_q == ST_IDLE), 32'd1);
    idle(1);
    send(0, 9'h096, 8, 8, 1'b0, 1'b0, 1, 2'b11, -1);
    idle(16);
    expect_frame("after_rst_96", 8'h96, 1'b0, 1'b0);
    check("total_overrun_cycles", 32'(ovr_cycles), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_gen.md
UART_RX_GEN -- requirements
Module: uart_rx_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter PRESCALE_W, default 6, width of prescale input.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port RX_IN  input  1  serial line, idle high, LSB first.
REQ-006 SHALL have port prescale  input  PRESCALE_W  clocks per bit; values below 4 treated as 4.
REQ-007 SHALL have port PAR_EN  input  1  1 = parity bit present.
REQ-008 SHALL have port PAR_TYP  input  1  0 = even, 1 = odd.
REQ-009 SHALL have port STOP2  input  1  1 = two stop bits expected.
REQ-010 SHALL have port data_ready  input  1  consumer accepts held frame.
REQ-011 SHALL have port P_DATA  output  DATA_W  received data.
REQ-012 SHALL have port data_valid  output  1  P_DATA and flags valid, held until accepted.
REQ-013 SHALL have ports parity_error, stop_error  output  1 each  flags belonging to held frame.
REQ-014 SHALL have port overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-015 RX_IN SHALL pass through a 2-flop synchroniser (reset value 1) before any use.
REQ-016 States SHALL be IDLE, START, DATA, PARITY, STOP; DATA repeats DATA_W times, STOP once or twice.
REQ-017 IDLE -> START SHALL occur only on a synchronised high-to-low transition, not a low level.
REQ-018 prescale, PAR_EN, PAR_TYP, STOP2 SHALL be latched on the start transition; mid-frame changes ignored.
REQ-019 Bit counter SHALL count 0..P-1 per bit (P = latched prescale), count 0 being the cycle after the start transition.
REQ-020 Each bit value SHALL be the 2-of-3 majority of samples at counts P/2-1, P/2, P/2+1 (integer division).
REQ-021 START majority of 1 SHALL return to IDLE with no output change (glitch rejection).
REQ-022 PARITY state SHALL be skipped when PAR_EN=0; parity_error = XOR(data, parity bit) != PAR_TYP.
REQ-023 stop_error SHALL be set if any stop-bit majority is 0.
REQ-024 Commit SHALL occur the cycle after the last stop-bit sample; FSM then enters IDLE immediately (remainder of stop bit not waited).
REQ-025 At commit with data_valid=0, or data_valid=1 and data_ready=1: P_DATA and flags SHALL load, data_valid=1 next cycle.
REQ-026 At commit with data_valid=1 and data_ready=0: new frame SHALL be dropped, held frame kept, overrun pulsed one cycle.
REQ-027 data_valid SHALL clear the cycle after data_valid and data_ready both high, absent simultaneous commit.
REQ-028 Frames with parity or stop errors SHALL still be delivered with flags set.
REQ-029 Break (line held low) SHALL deliver all-zero data with stop_error=1; no further frame until line returns high then falls.

Reset
REQ-030 On rst: FSM IDLE, counters 0, synchroniser 1, P_DATA 0, data_valid 0, parity_error 0, stop_error 0, overrun 0.
REQ-031 rst asserted mid-frame SHALL abort the frame without delivery; after release the next falling edge starts a new frame.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state encoding, PRESCALE_MIN = 4 and the DATA_W legal range.
REQ-033 Synchroniser plus 3-sample majority voter SHALL be sub-module uart_rx_sampler; FSM, counters and output register stay in uart_rx_gen.

Verification
REQ-034 DATA_W=8, P=8, 8N1, send 0xA5 then 0x3C, data_ready=1 -> two data_valid pulses, P_DATA 0xA5, 0x3C, no flags.
REQ-035 P=8, PAR_EN=1, PAR_TYP=0, send 0x55 with parity bit 1 -> P_DATA 0x55, parity_error=1, stop_error=0.
REQ-036 DATA_W=7, P=16, odd parity, STOP2=1, send 0x3F, second stop bit 0 -> P_DATA 0x3F, parity_error=0, stop_error=1.
REQ-037 P=8, 2-cycle low pulse on idle line -> no data_valid, FSM back in IDLE; following 0x5A frame received correctly.
REQ-038 data_ready=0, send 0x11 then 0x22 -> P_DATA 0x11 held, overrun one-cycle pulse at second commit.
REQ-039 Line low for 12 bit times, then rst high mid next frame -> one frame 0x00 with stop_error=1, then no output until a fresh frame after reset.
